// File: rtl/unidade_controle_jogo.sv
// ============================================================================
// unidade_controle_jogo : Moore control FSM for the sequence-memory game.
// Build option UC_TIMEOUT_EN enables the play-timeout path (fim_timeout).
// Revision 1.0
// ============================================================================
`default_nettype none

module unidade_controle_jogo (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       igual,
   input  logic       enderecoIgualLimite,
   input  logic       fim_jogo,
   input  logic       jogada_feita,
   input  logic       timeout,
   output logic       zera_endereco,
   output logic       conta_endereco,
   output logic       zera_limite,
   output logic       conta_limite,
   output logic       zeraR,
   output logic       registrarR,
   output logic       zera_s_timeout,
   output logic       enable_timeout,
   output logic       zera_modo,
   output logic       registra_modo,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic [3:0] db_estado,
   output logic       db_timeout
);

   typedef enum logic [3:0] {
      INICIAL        = 4'b0000,
      PREPARACAO     = 4'b0001,
      INICIA_RODADA  = 4'b0010,
      ESPERA_JOGADA  = 4'b0011,
      REGISTRA       = 4'b0100,
      COMPARACAO     = 4'b0101,
      PROXIMO        = 4'b0110,
      PROXIMA_RODADA = 4'b0111,
      FIM_ACERTOU    = 4'b1010,
      FIM_ERROU      = 4'b1110,
      FIM_TIMEOUT    = 4'b1101
   } state_t;

   typedef struct packed {
      logic zera_endereco;
      logic conta_endereco;
      logic zera_limite;
      logic conta_limite;
      logic zeraR;
      logic registrarR;
      logic zera_s_timeout;
      logic enable_timeout;
      logic zera_modo;
      logic registra_modo;
      logic pronto;
      logic acertou;
      logic errou;
      logic db_timeout;
   } ctrl_t;

   state_t state_q;
   state_t state_d;
   ctrl_t  ctrl_q;

   // Outputs are registered from the decode of the next state, so each output
   // register always reflects the state register it is paired with.
   function automatic ctrl_t decode(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         INICIAL:        c.zera_modo = 1'b1;
         PREPARACAO: begin
            c.zera_limite   = 1'b1;
            c.zeraR         = 1'b1;
            c.registra_modo = 1'b1;
         end
         INICIA_RODADA: begin
            c.zera_endereco  = 1'b1;
            c.zera_s_timeout = 1'b1;
         end
`ifdef UC_TIMEOUT_EN
         ESPERA_JOGADA:  c.enable_timeout = 1'b1;
`endif
         REGISTRA: begin
            c.registrarR     = 1'b1;
            c.zera_s_timeout = 1'b1;
         end
         PROXIMO:        c.conta_endereco = 1'b1;
         PROXIMA_RODADA: c.conta_limite = 1'b1;
         FIM_ACERTOU: begin
            c.pronto  = 1'b1;
            c.acertou = 1'b1;
         end
         FIM_ERROU: begin
            c.pronto = 1'b1;
            c.errou  = 1'b1;
         end
`ifdef UC_TIMEOUT_EN
         FIM_TIMEOUT: begin
            c.pronto     = 1'b1;
            c.errou      = 1'b1;
            c.db_timeout = 1'b1;
         end
`endif
         default:        c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = state_q;
      case (state_q)
         INICIAL:        state_d = iniciar ? PREPARACAO : INICIAL;
         PREPARACAO:     state_d = INICIA_RODADA;
         INICIA_RODADA:  state_d = ESPERA_JOGADA;
         ESPERA_JOGADA: begin
            // A play in the same cycle as the timeout wins.
            if (jogada_feita)
               state_d = REGISTRA;
`ifdef UC_TIMEOUT_EN
            else if (timeout)
               state_d = FIM_TIMEOUT;
`endif
            else
               state_d = ESPERA_JOGADA;
         end
         REGISTRA:       state_d = COMPARACAO;
         COMPARACAO: begin
            if (!igual)
               state_d = FIM_ERROU;
            else if (!enderecoIgualLimite)
               state_d = PROXIMO;
            else if (fim_jogo)
               state_d = FIM_ACERTOU;
            else
               state_d = PROXIMA_RODADA;
         end
         PROXIMO:        state_d = ESPERA_JOGADA;
         PROXIMA_RODADA: state_d = INICIA_RODADA;
         FIM_ACERTOU,
         FIM_ERROU:      state_d = iniciar ? PREPARACAO : state_q;
`ifdef UC_TIMEOUT_EN
         FIM_TIMEOUT:    state_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
         default:        state_d = INICIAL;
      endcase
   end

`ifndef UC_TIMEOUT_EN
   logic unused_timeout;
   assign unused_timeout = timeout;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= INICIAL;
         ctrl_q  <= decode(INICIAL);
      end else begin
         state_q <= state_d;
         ctrl_q  <= decode(state_d);
      end
   end

   assign zera_endereco  = ctrl_q.zera_endereco;
   assign conta_endereco = ctrl_q.conta_endereco;
   assign zera_limite    = ctrl_q.zera_limite;
   assign conta_limite   = ctrl_q.conta_limite;
   assign zeraR          = ctrl_q.zeraR;
   assign registrarR     = ctrl_q.registrarR;
   assign zera_s_timeout = ctrl_q.zera_s_timeout;
   assign enable_timeout = ctrl_q.enable_timeout;
   assign zera_modo      = ctrl_q.zera_modo;
   assign registra_modo  = ctrl_q.registra_modo;
   assign pronto         = ctrl_q.pronto;
   assign acertou        = ctrl_q.acertou;
   assign errou          = ctrl_q.errou;
   assign db_timeout     = ctrl_q.db_timeout;
   assign db_estado      = state_q;

endmodule

`default_nettype wire

// File: doc/unidade_controle_jogo.md
UNIDADE_CONTROLE_JOGO -- requirements
Module: unidade_controle_jogo

Interface
REQ-001 The module SHALL have no parameters; the port list SHALL be exactly as follows.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 iniciar  input  1  start request; sampled only in inicial and the three fim states.
REQ-005 igual  input  1  stored play equals current ROM word.
REQ-006 enderecoIgualLimite  input  1  sequence address equals round limit (last play of round).
REQ-007 fim_jogo  input  1  round limit equals final round for the selected mode.
REQ-008 jogada_feita  input  1  one-cycle pulse when a button press is detected.
REQ-009 timeout  input  1  timeout counter reached its end.
REQ-010 zera_endereco, conta_endereco, zera_limite, conta_limite, zeraR, registrarR, zera_s_timeout, enable_timeout, zera_modo, registra_modo  output  1 each  datapath control strobes.
REQ-011 pronto  output  1  game finished, any outcome.
REQ-012 acertou  output  1  game won.
REQ-013 errou  output  1  game lost by wrong play or timeout.
REQ-014 db_estado  output  4  current state code.
REQ-015 db_timeout  output  1  game ended by timeout.

Function
REQ-016 The FSM SHALL be Moore: every output SHALL be decoded from the current state only.
REQ-017 State codes SHALL be inicial=0000, preparacao=0001, inicia_rodada=0010, espera_jogada=0011, registra=0100, comparacao=0101, proximo=0110, proxima_rodada=0111, fim_acertou=1010, fim_errou=1110, fim_timeout=1101; unused codes SHALL go to inicial on the next edge.
REQ-018 inicial: iniciar=1 -> preparacao, else hold.
REQ-019 preparacao: zera_limite=zeraR=zera_modo... no -- zera_limite=1, zeraR=1, registra_modo=1; -> inicia_rodada unconditionally.
REQ-020 inicia_rodada: zera_endereco=1, zera_s_timeout=1; -> espera_jogada.
REQ-021 espera_jogada: enable_timeout=1; jogada_feita=1 -> registra; else timeout=1 -> fim_timeout; else hold.
REQ-022 jogada_feita and timeout asserted in the same cycle SHALL resolve to registra.
REQ-023 registra: registrarR=1, zera_s_timeout=1; -> comparacao (one cycle so the synchronous ROM output is valid).
REQ-024 comparacao: igual=0 -> fim_errou; igual=1 and enderecoIgualLimite=0 -> proximo; igual=1, enderecoIgualLimite=1, fim_jogo=1 -> fim_acertou; igual=1, enderecoIgualLimite=1, fim_jogo=0 -> proxima_rodada.
REQ-025 proximo: conta_endereco=1; -> espera_jogada.
REQ-026 proxima_rodada: conta_limite=1; -> inicia_rodada.
REQ-027 fim_acertou: pronto=acertou=1; fim_errou: pronto=errou=1; fim_timeout: pronto=errou=db_timeout=1; iniciar=1 -> preparacao, else hold.
REQ-028 iniciar SHALL be ignored in all states except inicial and fim states.
REQ-029 All strobes not listed for a state SHALL be 0 in that state.
REQ-030 Latency SHALL be: jogada_feita pulse -> registrarR asserted in the next cycle -> decision state entered two cycles after the pulse.

Reset
REQ-031 reset=1 at a rising edge SHALL force inicial from any state, overriding every other input.
REQ-032 In inicial all outputs SHALL be 0 except zera_modo=1, and db_estado=0000.
REQ-033 reset asserted mid-round SHALL leave no residual strobe; the game restarts only through iniciar.

Configuration
REQ-034 With macro UC_TIMEOUT_EN defined, timeout handling SHALL be exactly as REQ-021.
REQ-035 Without UC_TIMEOUT_EN, enable_timeout SHALL be constant 0, the timeout input SHALL be ignored, fim_timeout SHALL be unreachable, and db_timeout SHALL be constant 0.

Verification
REQ-036 reset=1 one edge, then iniciar=0 for 5 cycles -> db_estado=0000, zera_modo=1, all other outputs 0.
REQ-037 iniciar pulse; correct plays with fim_jogo=1 at first limit -> states 0001,0010,0011,0100,0101,1010; pronto=acertou=1.
REQ-038 Round of 3 plays, second play igual=0 -> conta_endereco pulses once, then 1110; errou=1, acertou=0.
REQ-039 In espera_jogada, timeout=1 with jogada_feita=0 -> 1101, db_timeout=1 (UC_TIMEOUT_EN); without macro -> stays 0011, enable_timeout=0.
REQ-040 jogada_feita=timeout=1 same cycle -> next state 0100; reset=1 in 0101 -> 0000 next edge; iniciar in 1010 -> 0001.
